video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 110 +++++++++++
 tb/tb_video_timing_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - Raster timing generator producing hsync/vsync/de/x/y and sol/sof pulses.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_PW      = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_PW      = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sol,
    output logic          sof
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_PW + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_PW + V_BP;
    localparam int H_SS  = H_VISIBLE + H_FP;
    localparam int H_SE  = H_VISIBLE + H_FP + H_PW;
    localparam int V_SS  = V_VISIBLE + V_FP;
    localparam int V_SE  = V_VISIBLE + V_FP + V_PW;

    if ((H_TOT - 1 > (2 ** CW) - 1) || (V_TOT - 1 > (2 ** CW) - 1) ||
        (H_PW == 0) || (V_PW == 0) || (H_VISIBLE == 0) || (V_VISIBLE == 0)) begin : g_bad_cfg
        $error("video_timing_gen: invalid timing parameters for CW=%0d", CW);
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    logic          h_vis;
    logic          v_vis;
    logic          hs_act;
    logic          vs_act;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_zero;
    logic          v_zero;

    // Decode is done in 32-bit space so sync-end bounds equal to H_TOT/V_TOT cannot overflow CW.
    assign h_ext  = {{(32-CW){1'b0}}, h_cnt};
    assign v_ext  = {{(32-CW){1'b0}}, v_cnt};
    assign h_vis  = h_ext < 32'(H_VISIBLE);
    assign v_vis  = v_ext < 32'(V_VISIBLE);
    assign hs_act = (h_ext >= 32'(H_SS)) && (h_ext < 32'(H_SE));
    assign vs_act = (v_ext >= 32'(V_SS)) && (v_ext < 32'(V_SE));
    assign h_wrap = h_ext == 32'(H_TOT - 1);
    assign v_wrap = v_ext == 32'(V_TOT - 1);
    assign h_zero = h_cnt == '0;
    assign v_zero = v_cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            sol   <= 1'b0;
            sof   <= 1'b0;
        end else begin
            // Pulses are one clk wide even when ce stays low afterwards.
            sol <= 1'b0;
            sof <= 1'b0;
            if (ce) begin
                h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
                if (h_wrap) begin
                    v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
                end
                de    <= h_vis && v_vis;
                x     <= (h_vis && v_vis) ? h_cnt : '0;
                y     <= (h_vis && v_vis) ? v_cnt : '0;
                hsync <= hs_act ? HS_POL : ~HS_POL;
                vsync <= vs_act ? VS_POL : ~VS_POL;
                sol   <= h_zero;
                sof   <= h_zero && v_zero;
            end
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (ce && h_zero && v_zero) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - Self-checking bench for video_timing_gen (default and reduced timing).
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ce, rst_s, ce_s;
    logic       hsync, vsync, de, sol, sof;
    logic [9:0] x, y;
    logic       hsync_s, vsync_s, de_s, sol_s, sof_s;
    logic [9:0] x_s, y_s;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fc, fc_s;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    video_timing_gen dut (
        .clk(clk), .rst(rst), .ce(ce), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .sol(sol), .sof(sof)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc)
`endif
    );

    video_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_PW(1), .H_BP(1),
        .V_VISIBLE(2), .V_FP(1), .V_PW(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .ce(ce_s), .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .x(x_s), .y(y_s), .sol(sol_s), .sof(sof_s)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    typedef struct {
        logic ce;
        logic de;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic sol;
        logic sof;
    } vec_t;

    vec_t vt[18];

    function automatic logic [31:0] pack(input logic d, input logic [9:0] px, input logic [9:0] py,
                                         input logic hs, input logic vs, input logic sl, input logic sf);
        return {7'b0, d, px, py, hs, vs, sl, sf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hs_start, hs_low, line_per, sol_hi, hold_err, vs_start, vs_hi, hs_hi, sof_per;
        logic [9:0] x_prev;
        logic found;

        // decoded small timing: h 0-3 visible, 4 fp, 5 sync, 6 bp; v 0-1 visible, 2 fp, 3 sync, 4 bp
        vt[0]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[17] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; ce = 1'b1; rst_s = 1'b1; ce_s = 1'b0;
        tick();
        tick();
        check("def_reset_state", pack(de, x, y, hsync, vsync, sol, sof), pack(0, 0, 0, 1, 1, 0, 0));
        check("small_reset_state", pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s), pack(0, 0, 0, 0, 0, 0, 0));

        rst_s = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ce_s = vt[i].ce;
            tick();
            check($sformatf("small_vec%0d", i), pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s),
                  pack(vt[i].de, vt[i].x[9:0], vt[i].y[9:0], vt[i].hs, vt[i].vs, vt[i].sol, vt[i].sof));
        end

        rst = 1'b0;
        tick();
        check("def_first_edge", pack(de, x, y, hsync, vsync, sol, sof), pack(1, 0, 0, 1, 1, 1, 1));
        tick();
        check("def_second_edge", pack(de, x, y, hsync, vsync, sol, sof), pack(1, 1, 0, 1, 1, 0, 0));
        hs_start = -1; hs_low = 0; line_per = -1;
        for (int n = 2; n <= 800; n++) begin
            tick();
            if (!hsync) begin
                if (hs_start < 0) hs_start = n + 1;
                hs_low++;
            end
            if (sol && line_per < 0) line_per = n;
        end
        check("hsync_first_low_clk_of_line", hs_start, 657);
        check("hsync_low_clks", hs_low, 96);
        check("line_period", line_per, 800);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        sol_hi = 0; line_per = -1; hold_err = 0; x_prev = 10'd0;
        for (int k = 0; k <= 1700; k++) begin
            ce = (k % 2 == 0);
            tick();
            if (sol) begin
                sol_hi++;
                if (k > 0 && line_per < 0) line_per = k;
            end
            if (!ce && x !== x_prev) hold_err++;
            x_prev = x;
            if (k == 5) check("ce_toggle_x_hold_value", x, 2);
        end
        check("ce_toggle_line_period", line_per, 1600);
        check("ce_toggle_sol_high_clks", sol_hi, 2);
        check("ce_toggle_x_hold_errors", hold_err, 0);

        rst_s = 1'b1; ce_s = 1'b1;
        tick();
        rst_s = 1'b0;
        tick();
        check("small_frame_first_sof", sof_s, 1);
`ifdef VTG_FRAME_CNT_EN
        check("frame_cnt_first", fc_s, 1);
`endif
        vs_start = -1; vs_hi = 0; hs_hi = 0; sof_per = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (vsync_s) begin
                if (vs_start < 0) vs_start = n;
                vs_hi++;
            end
            if (hsync_s && n < 35) hs_hi++;
            if (sof_s && sof_per < 0) sof_per = n;
        end
        check("small_vsync_start", vs_start, 21);
        check("small_vsync_high_edges", vs_hi, 7);
        check("small_hsync_high_per_frame", hs_hi, 5);
        check("small_frame_period", sof_per, 35);
`ifdef VTG_FRAME_CNT_EN
        check("frame_cnt_second", fc_s, 2);
`endif

        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            tick();
            if (de_s && x_s == 10'd2 && y_s == 10'd1) found = 1'b1;
        end
        check("midframe_target_reached", found, 1);
        rst_s = 1'b1;
        #1;
        check("midframe_reset_immediate", pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s), pack(0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("midframe_reset_hold%0d", n), pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s),
                  pack(0, 0, 0, 0, 0, 0, 0));
        end
        rst_s = 1'b0;
        tick();
        check("midframe_restart", pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s), pack(1, 0, 0, 0, 0, 1, 1));
        tick();
        check("midframe_sof_clears", pack(de_s, x_s, y_s, hsync_s, vsync_s, sol_s, sof_s), pack(1, 1, 0, 0, 0, 0, 0));

`ifdef VTG_FRAME_CNT_EN
        rst_s = 1'b1; ce_s = 1'b0;
        tick();
        rst_s = 1'b0;
        tick();
        force dut_s.frame_cnt = 16'hFFFF;
        #1;
        release dut_s.frame_cnt;
        ce_s = 1'b1;
        tick();
        check("frame_cnt_wrap_sof", sof_s, 1);
        check("frame_cnt_wrap", fc_s, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
